// File: rtl/ext_int_ctrl.sv
// ext_int_ctrl: machine external interrupt controller. Synchronises peripheral
// lines, latches pending requests, arbitrates by lowest ID and runs claim/complete.
module ext_int_ctrl #(
   parameter int unsigned NUM_SRC     = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst_sync,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic [3:0]         bus_addr,
   input  logic               bus_re,
   input  logic               bus_we,
   input  logic [31:0]        bus_wdata,
   output logic [31:0]        bus_rdata,
   output logic               meip,
   output logic [26:0]        custom_int_code
);
   typedef enum logic [1:0] {
      REG_PENDING = 2'd0,
      REG_ENABLE  = 2'd1,
      REG_TRIGGER = 2'd2,
      REG_CLAIM   = 2'd3
   } reg_sel_e;

   logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
   logic [NUM_SRC-1:0] prev_q;
   logic [NUM_SRC-1:0] pending_q;
   logic [NUM_SRC-1:0] enable_q;
   logic [NUM_SRC-1:0] trigger_q;
   logic [4:0]         in_service_q;
   logic [4:0]         code_q;

   logic [NUM_SRC-1:0] sync_s;
   logic [NUM_SRC-1:0] req;
   logic [NUM_SRC-1:0] set_mask;
   logic [NUM_SRC-1:0] clr_mask;
   logic [4:0]         win_id;
   reg_sel_e           sel;
   logic               wr_en;
   logic               claim;
   logic               complete;
   logic [31:0]        rdata_nxt;
   logic               unused_bits;

   assign sync_s   = sync_q[SYNC_STAGES-1];
   assign sel      = reg_sel_e'(bus_addr[3:2]);
   assign req      = pending_q & enable_q;
   assign set_mask = (trigger_q & sync_s & ~prev_q) | (~trigger_q & sync_s);
   // A simultaneous read wins over the write on the same cycle.
   assign wr_en    = bus_we & ~bus_re;
   assign claim    = bus_re && (sel == REG_CLAIM) && (in_service_q == '0);
   assign complete = wr_en && (sel == REG_CLAIM) && (in_service_q != '0)
                     && (bus_wdata[4:0] == in_service_q);

   assign unused_bits = ^{bus_addr[1:0], bus_wdata};

   // Descending scan so the lowest requesting index is the last to assign.
   always_comb begin
      win_id = '0;
      for (int unsigned i = NUM_SRC; i > 0; i--) begin
         if (req[i-1]) win_id = 5'(i);
      end
   end

   always_comb begin
      clr_mask = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         clr_mask[i] = claim && (win_id == 5'(i + 1));
      end
   end

   always_comb begin
      rdata_nxt = '0;
      if (bus_re) begin
         case (sel)
            REG_PENDING: rdata_nxt = 32'(pending_q);
            REG_ENABLE:  rdata_nxt = 32'(enable_q);
            REG_TRIGGER: rdata_nxt = 32'(trigger_q);
            REG_CLAIM:   rdata_nxt = claim ? 32'(win_id) : '0;
            default:     rdata_nxt = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_sync) begin
         for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
         prev_q       <= '0;
         pending_q    <= '0;
         enable_q     <= '0;
         trigger_q    <= '0;
         in_service_q <= '0;
         code_q       <= '0;
         meip         <= 1'b0;
         bus_rdata    <= '0;
      end else begin
         sync_q[0] <= irq_src;
         for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
         prev_q    <= sync_s;
         // New set beats claim-clear on the same bit.
         pending_q <= (pending_q & ~clr_mask) | set_mask;
         if (wr_en && (sel == REG_ENABLE))  enable_q  <= bus_wdata[NUM_SRC-1:0];
         if (wr_en && (sel == REG_TRIGGER)) trigger_q <= bus_wdata[NUM_SRC-1:0];
         if (claim)         in_service_q <= win_id;
         else if (complete) in_service_q <= '0;
         meip      <= (req != '0) && (in_service_q == '0);
         code_q    <= win_id;
         bus_rdata <= rdata_nxt;
      end
   end

   assign custom_int_code = {22'd0, code_q};

endmodule

// File: tb/tb_ext_int_ctrl.sv
// tb_ext_int_ctrl: directed scenarios plus randomized traffic, checked every
// cycle against a delay-line / bitmask reference model of the controller.
module tb_ext_int_ctrl;
   localparam int NSRC = 8;
   localparam int SYN  = 2;
   localparam int unsigned MASK = (1 << NSRC) - 1;

   logic            clk = 1'b0;
   logic            rst_sync;
   logic [NSRC-1:0] irq_src;
   logic [3:0]      bus_addr;
   logic            bus_re;
   logic            bus_we;
   logic [31:0]     bus_wdata;
   logic [31:0]     bus_rdata;
   logic            meip;
   logic [26:0]     custom_int_code;

   ext_int_ctrl #(.NUM_SRC(NSRC), .SYNC_STAGES(SYN)) dut (
      .clk(clk), .rst_sync(rst_sync), .irq_src(irq_src),
      .bus_addr(bus_addr), .bus_re(bus_re), .bus_we(bus_we),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .meip(meip), .custom_int_code(custom_int_code)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference state: hist[k] holds the irq_src sample taken k+1 edges ago.
   int unsigned hist[$];
   int unsigned m_pend, m_en, m_trig, m_isv, m_code, m_rdata;
   bit          m_meip;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int unsigned lowest_id(input int unsigned req);
      for (int i = 0; i < NSRC; i++) if (req[i]) return i + 1;
      return 0;
   endfunction

   task automatic model_clear();
      hist.delete();
      for (int i = 0; i <= SYN; i++) hist.push_back(0);
      m_pend = 0; m_en = 0; m_trig = 0; m_isv = 0;
      m_code = 0; m_rdata = 0; m_meip = 0;
   endtask

   // One clock: model advances on the same inputs the DUT samples, then compare.
   task automatic tick();
      int unsigned s, prev, req, w, set, clr, sel;
      int unsigned n_pend, n_en, n_trig, n_isv, n_rdata;
      bit          claim, wr, rd_cyc;
      rd_cyc = bus_re || rst_sync;
      if (rst_sync) begin
         model_clear();
      end else begin
         sel  = bus_addr >> 2;
         s    = hist[SYN-1];
         prev = hist[SYN];
         req  = m_pend & m_en;
         w    = lowest_id(req);
         set  = ((m_trig & s & ~prev) | (~m_trig & s)) & MASK;
         claim = bus_re && sel == 3 && m_isv == 0;
         wr    = bus_we && !bus_re;
         n_rdata = 0;
         if (bus_re) begin
            case (sel)
               0: n_rdata = m_pend;
               1: n_rdata = m_en;
               2: n_rdata = m_trig;
               default: n_rdata = claim ? w : 0;
            endcase
         end
         clr    = (claim && w != 0) ? (1 << (w - 1)) : 0;
         n_pend = (m_pend & ~clr) | set;
         n_en   = (wr && sel == 1) ? (bus_wdata & MASK) : m_en;
         n_trig = (wr && sel == 2) ? (bus_wdata & MASK) : m_trig;
         n_isv  = m_isv;
         if (claim) n_isv = w;
         else if (wr && sel == 3 && m_isv != 0 && (bus_wdata % 32) == m_isv) n_isv = 0;
         m_meip  = (req != 0) && (m_isv == 0);
         m_code  = w;
         m_pend  = n_pend; m_en = n_en; m_trig = n_trig; m_isv = n_isv;
         m_rdata = n_rdata;
         hist.push_front(int'(irq_src));
         void'(hist.pop_back());
      end
      @(posedge clk);
      #1;
      check("meip", 32'(meip), 32'(m_meip));
      check("code", 32'(custom_int_code), m_code);
      if (rd_cyc) check("rdata", bus_rdata, m_rdata);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
      bus_addr = a; bus_re = 1'b1;
      tick();
      d = bus_rdata;
      bus_re = 1'b0;
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      bus_addr = a; bus_wdata = d; bus_we = 1'b1;
      tick();
      bus_we = 1'b0;
   endtask

   logic [31:0] rd;

   initial begin
      rst_sync = 1'b1; irq_src = '0; bus_addr = '0;
      bus_re = 1'b0; bus_we = 1'b0; bus_wdata = '0;
      model_clear();
      idle(2);
      check("reset_meip", 32'(meip), 32'd0);
      check("reset_code", 32'(custom_int_code), 32'd0);
      check("reset_rdata", bus_rdata, 32'd0);
      rst_sync = 1'b0;

      // 1: single edge pulse on ID1
      bus_write(4'h4, 32'h05);
      bus_write(4'h8, 32'h01);
      irq_src = 8'h01; tick();
      irq_src = 8'h00; idle(2);
      bus_read(4'h0, rd);
      check("t1_pending", rd, 32'h01);
      check("t1_meip", 32'(meip), 32'd1);
      check("t1_code", 32'(custom_int_code), 32'd1);
      bus_read(4'hC, rd);
      check("t1_claim", rd, 32'd1);
      bus_write(4'hC, 32'd1);
      idle(2);

      // 2: ID3 and ID5 edges together, lowest ID wins
      bus_write(4'h4, 32'h14);
      bus_write(4'h8, 32'h14);
      irq_src = 8'h14; tick();
      irq_src = 8'h00; idle(3);
      check("t2_code3", 32'(custom_int_code), 32'd3);
      bus_read(4'hC, rd);
      check("t2_claim3", rd, 32'd3);
      tick();
      check("t2_meip_drop", 32'(meip), 32'd0);
      bus_write(4'hC, 32'd3);
      tick();
      check("t2_meip_back", 32'(meip), 32'd1);
      check("t2_code5", 32'(custom_int_code), 32'd5);
      bus_read(4'hC, rd);
      check("t2_claim5", rd, 32'd5);
      bus_write(4'hC, 32'd5);
      idle(2);

      // 3: level source ID2
      bus_write(4'h4, 32'h02);
      bus_write(4'h8, 32'h00);
      irq_src = 8'h02; idle(4);
      bus_read(4'hC, rd);
      check("t3_claim", rd, 32'd2);
      idle(2);
      check("t3_meip_svc", 32'(meip), 32'd0);
      bus_write(4'hC, 32'd2);
      tick();
      check("t3_meip_repend", 32'(meip), 32'd1);
      bus_read(4'hC, rd);
      check("t3_claim2", rd, 32'd2);
      irq_src = 8'h00; idle(4);
      bus_read(4'h0, rd);
      check("t3_latched", rd, 32'h02);
      bus_write(4'hC, 32'd2);
      tick();
      check("t3_meip_latched", 32'(meip), 32'd1);
      bus_read(4'hC, rd);
      check("t3_claim3", rd, 32'd2);
      bus_write(4'hC, 32'd2);
      idle(3);
      check("t3_meip_quiet", 32'(meip), 32'd0);

      // 4: wrong-ID complete and nested claim are ignored
      irq_src = 8'h02; idle(4);
      bus_read(4'hC, rd);
      check("t4_claim", rd, 32'd2);
      bus_write(4'hC, 32'd4);
      idle(2);
      check("t4_meip", 32'(meip), 32'd0);
      bus_read(4'hC, rd);
      check("t4_nested", rd, 32'd0);
      irq_src = 8'h00; idle(4);
      bus_write(4'hC, 32'd2);
      bus_read(4'hC, rd);
      bus_write(4'hC, 32'd2);
      idle(2);

      // 5: masked pending, then re-enable
      bus_write(4'h4, 32'h00);
      bus_write(4'h8, 32'h08);
      irq_src = 8'h08; tick();
      irq_src = 8'h00; idle(4);
      bus_read(4'h0, rd);
      check("t5_pending", rd, 32'h08);
      check("t5_meip_off", 32'(meip), 32'd0);
      bus_read(4'hC, rd);
      check("t5_claim_none", rd, 32'd0);
      bus_write(4'h4, 32'h08);
      tick();
      check("t5_meip_on", 32'(meip), 32'd1);
      check("t5_code", 32'(custom_int_code), 32'd4);
      bus_read(4'hC, rd);
      bus_write(4'hC, 32'd4);
      idle(2);

      // 6: reset while in service
      bus_write(4'h4, 32'hFF);
      bus_write(4'h8, 32'hFF);
      irq_src = 8'h64; tick();
      irq_src = 8'h00; idle(4);
      bus_read(4'hC, rd);
      check("t6_claim", rd, 32'd3);
      rst_sync = 1'b1; tick(); rst_sync = 1'b0;
      check("t6_meip", 32'(meip), 32'd0);
      check("t6_code", 32'(custom_int_code), 32'd0);
      check("t6_rdata", bus_rdata, 32'd0);
      for (int a = 0; a < 16; a += 4) begin
         bus_read(4'(a), rd);
         check("t6_reg", rd, 32'd0);
      end

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         int unsigned r;
         if ($urandom_range(7) == 0) irq_src = irq_src ^ NSRC'(1 << $urandom_range(NSRC - 1));
         r = $urandom_range(99);
         bus_addr  = 4'($urandom_range(15));
         bus_wdata = $urandom;
         if (r < 10) bus_re = 1'b1;
         else if (r < 18) begin bus_addr[3:2] = 2'd3; bus_re = 1'b1; end
         else if (r < 23) begin bus_addr[3:2] = 2'd1; bus_we = 1'b1; end
         else if (r < 27) begin bus_addr[3:2] = 2'd2; bus_we = 1'b1; end
         else if (r < 37) begin
            bus_addr[3:2] = 2'd3; bus_we = 1'b1;
            if ($urandom_range(1) == 0) bus_wdata[4:0] = 5'(m_isv);
         end
         else if (r < 40) begin bus_re = 1'b1; bus_we = 1'b1; end
         else if (r < 41) rst_sync = 1'b1;
         tick();
         bus_re = 1'b0; bus_we = 1'b0; rst_sync = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
